csr_mtrap_unit: RTL

- Parametrised machine-mode CSR file and trap controller for the rv64 core; successor to the single-timer M-mode CSR block.
- Adds three interrupt sources (software/timer/external) with fixed priority, vectored mtvec, mtval, minstret, mhartid and illegal-CSR detection.
- Sits beside EX/WB: decodes CSR accesses, commits trap entry/return, supplies redirect PCs to the fetch stage.

---
 rtl/csr_mtrap_unit_pkg.sv | 64 ++++++
 rtl/csr_mtrap_unit_irq_arb.sv | 55 +++++
 rtl/csr_mtrap_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/csr_mtrap_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_mtrap_unit_pkg
//  Description : CSR addresses, interrupt cause codes, mstatus bit positions
//                and the CSR address decoder shared by the M-mode trap unit.
//  Revision    : 1.0  initial release
// ============================================================================
package csr_mtrap_unit_pkg;

    localparam logic [11:0] c_CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] c_CSR_MIE      = 12'h304;
    localparam logic [11:0] c_CSR_MTVEC    = 12'h305;
    localparam logic [11:0] c_CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] c_CSR_MEPC     = 12'h341;
    localparam logic [11:0] c_CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] c_CSR_MTVAL    = 12'h343;
    localparam logic [11:0] c_CSR_MIP      = 12'h344;
    localparam logic [11:0] c_CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] c_CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] c_CSR_MHARTID  = 12'hF14;

    localparam logic [3:0] c_IRQ_MSI = 4'd3;
    localparam logic [3:0] c_IRQ_MTI = 4'd7;
    localparam logic [3:0] c_IRQ_MEI = 4'd11;

    localparam int c_MS_MIE    = 3;
    localparam int c_MS_MPIE   = 7;
    localparam int c_MS_MPP_LO = 11;
    localparam int c_MS_FS_LO  = 13;

    typedef enum logic [3:0] {
        CSR_NONE,
        CSR_MSTATUS,
        CSR_MIE,
        CSR_MTVEC,
        CSR_MSCRATCH,
        CSR_MEPC,
        CSR_MCAUSE,
        CSR_MTVAL,
        CSR_MIP,
        CSR_MCYCLE,
        CSR_MINSTRET,
        CSR_MHARTID
    } csr_sel_e;

    function automatic csr_sel_e csr_decode(input logic [11:0] idx);
        case (idx)
            c_CSR_MSTATUS:  return CSR_MSTATUS;
            c_CSR_MIE:      return CSR_MIE;
            c_CSR_MTVEC:    return CSR_MTVEC;
            c_CSR_MSCRATCH: return CSR_MSCRATCH;
            c_CSR_MEPC:     return CSR_MEPC;
            c_CSR_MCAUSE:   return CSR_MCAUSE;
            c_CSR_MTVAL:    return CSR_MTVAL;
            c_CSR_MIP:      return CSR_MIP;
            c_CSR_MCYCLE:   return CSR_MCYCLE;
            c_CSR_MINSTRET: return CSR_MINSTRET;
            c_CSR_MHARTID:  return CSR_MHARTID;
            default:        return CSR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_mtrap_unit_irq_arb.sv
`default_nettype none
// ============================================================================
//  Module      : csr_irq_arb
//  Description : Synchronises MSIP/MTIP/MEIP into mip and picks the highest
//                priority enabled interrupt (MEI > MSI > MTI).
//  Revision    : 1.0  initial release
// ============================================================================
module csr_irq_arb
    import csr_mtrap_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_irq_sw,
    input  logic       i_irq_tmr,
    input  logic       i_irq_ext,
    input  logic [2:0] i_mie,        // {MEIE, MTIE, MSIE}
    input  logic       i_gie,
    input  logic       i_pc_valid,
    input  logic       i_stall,
    input  logic       i_exc_valid,
    output logic [2:0] o_mip,        // {MEIP, MTIP, MSIP}
    output logic       o_irq_take,
    output logic [3:0] o_irq_code
);

    logic [2:0] r_mip;
    logic [2:0] w_pend;

    // The sync keeps running through stalls so mip never goes stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mip <= 3'b000;
        end else begin
            r_mip <= {i_irq_ext, i_irq_tmr, i_irq_sw};
        end
    end

    assign w_pend = r_mip & i_mie;

    always_comb begin
        o_irq_code = 4'd0;
        if (w_pend[2]) begin
            o_irq_code = c_IRQ_MEI;
        end else if (w_pend[0]) begin
            o_irq_code = c_IRQ_MSI;
        end else if (w_pend[1]) begin
            o_irq_code = c_IRQ_MTI;
        end
    end

    assign o_irq_take = (|w_pend) & i_gie & i_pc_valid & ~i_stall & ~i_exc_valid;
    assign o_mip      = r_mip;

endmodule
`default_nettype wire

// File: rtl/csr_mtrap_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_mtrap_unit
//  Description : Machine-mode CSR file and trap controller: CSR decode,
//                trap entry/return and redirect PCs for fetch.
//  Revision    : 1.0  initial release
// ============================================================================
module csr_mtrap_unit
    import csr_mtrap_unit_pkg::*;
#(
    parameter int          XLEN    = 64,
    parameter bit          VEC_EN  = 1'b1,
    parameter int unsigned HART_ID = 0,
    parameter bit          CNT_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] wbck_csr_data,
    output logic [XLEN-1:0] read_csr_data,
    input  logic            mret_i,
    input  logic            exc_valid_i,
    input  logic [4:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            retire_i,
    input  logic            stall_i,
    input  logic            irq_sw_i,
    input  logic            irq_tmr_i,
    input  logic            irq_ext_i,
    output logic            trap_valid_o,
    output logic [XLEN-1:0] trap_pc_o,
    output logic [XLEN-1:0] mret_pc_o,
    output logic            illegal_csr_o
);

    logic            r_ms_mie;
    logic            r_ms_mpie;
    logic [1:0]      r_ms_mpp;
    logic [1:0]      r_ms_fs;
    logic [2:0]      r_mie;          // {MEIE, MTIE, MSIE}
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mscratch;

    logic [XLEN-1:0] w_mcycle;
    logic [XLEN-1:0] w_minstret;
    logic [2:0]      w_mip;
    logic            w_irq_take;
    logic [3:0]      w_irq_code;
    csr_sel_e        w_sel;
    logic            w_illegal;
    logic            w_trap;
    logic            w_wr;
    logic            w_mret;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_base;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_irq_cause;
    logic [1:0]      w_mtvec_mode;

    csr_irq_arb u_irq_arb (
        .clk         (clk),
        .rst         (rst),
        .i_irq_sw    (irq_sw_i),
        .i_irq_tmr   (irq_tmr_i),
        .i_irq_ext   (irq_ext_i),
        .i_mie       (r_mie),
        .i_gie       (r_ms_mie),
        .i_pc_valid  (pc_i != '0),
        .i_stall     (stall_i),
        .i_exc_valid (exc_valid_i),
        .o_mip       (w_mip),
        .o_irq_take  (w_irq_take),
        .o_irq_code  (w_irq_code)
    );

    assign w_sel     = csr_decode(csr_idx);
    assign w_illegal = (csr_rd_en | csr_wr_en) &
                       ((w_sel == CSR_NONE) |
                        (csr_wr_en & ((w_sel == CSR_MIP) | (w_sel == CSR_MHARTID))));

    // Trap beats both mret and any CSR write committing in the same cycle.
    assign w_trap = (exc_valid_i & ~stall_i) | w_irq_take;
    assign w_wr   = csr_wr_en & ~w_illegal & ~stall_i & ~w_trap;
    assign w_mret = mret_i & ~stall_i & ~w_trap;

    assign w_base       = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_trap_pc    = (w_irq_take && r_mtvec[1:0] == 2'b01)
                        ? w_base + XLEN'({w_irq_code, 2'b00}) : w_base;
    assign w_irq_cause  = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
    assign w_mtvec_mode = (VEC_EN && wbck_csr_data[1:0] == 2'b01) ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms_mie   <= 1'b0;
            r_ms_mpie  <= 1'b0;
            r_ms_mpp   <= 2'b00;
            r_ms_fs    <= 2'b00;
            r_mie      <= 3'b000;
            r_mtvec    <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mscratch <= '0;
        end else if (w_trap) begin
            r_mepc    <= {pc_i[XLEN-1:2], 2'b00};
            r_ms_mpie <= r_ms_mie;
            r_ms_mie  <= 1'b0;
            r_ms_mpp  <= 2'b11;
            if (exc_valid_i) begin
                r_mcause <= XLEN'(exc_cause_i);
                r_mtval  <= exc_tval_i;
            end else begin
                r_mcause <= w_irq_cause;
                r_mtval  <= '0;
            end
        end else if (w_mret) begin
            r_ms_mie  <= r_ms_mpie;
            r_ms_mpie <= 1'b1;
            r_ms_mpp  <= 2'b00;
        end else if (w_wr) begin
            case (w_sel)
                CSR_MSTATUS: begin
                    r_ms_mie  <= wbck_csr_data[c_MS_MIE];
                    r_ms_mpie <= wbck_csr_data[c_MS_MPIE];
                    r_ms_mpp  <= wbck_csr_data[c_MS_MPP_LO +: 2];
                    r_ms_fs   <= wbck_csr_data[c_MS_FS_LO +: 2];
                end
                CSR_MIE:      r_mie      <= {wbck_csr_data[11], wbck_csr_data[7], wbck_csr_data[3]};
                CSR_MTVEC:    r_mtvec    <= {wbck_csr_data[XLEN-1:2], w_mtvec_mode};
                CSR_MSCRATCH: r_mscratch <= wbck_csr_data;
                CSR_MEPC:     r_mepc     <= {wbck_csr_data[XLEN-1:2], 2'b00};
                CSR_MCAUSE:   r_mcause   <= wbck_csr_data;
                CSR_MTVAL:    r_mtval    <= wbck_csr_data;
                default: ;
            endcase
        end
    end

    generate
        if (CNT_EN) begin : g_cnt
            logic [XLEN-1:0] r_mcycle;
            logic [XLEN-1:0] r_minstret;

            // mcycle ignores stall; a write replaces that cycle's increment.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mcycle <= '0;
                end else if (w_wr && w_sel == CSR_MCYCLE) begin
                    r_mcycle <= wbck_csr_data;
                end else begin
                    r_mcycle <= r_mcycle + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_minstret <= '0;
                end else if (w_wr && w_sel == CSR_MINSTRET) begin
                    r_minstret <= wbck_csr_data;
                end else if (retire_i && !stall_i) begin
                    r_minstret <= r_minstret + 1'b1;
                end
            end

            assign w_mcycle   = r_mcycle;
            assign w_minstret = r_minstret;
        end else begin : g_no_cnt
            assign w_mcycle   = '0;
            assign w_minstret = '0;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (w_sel)
            CSR_MSTATUS: begin
                w_rdata[c_MS_MIE]          = r_ms_mie;
                w_rdata[c_MS_MPIE]         = r_ms_mpie;
                w_rdata[c_MS_MPP_LO +: 2]  = r_ms_mpp;
                w_rdata[c_MS_FS_LO +: 2]   = r_ms_fs;
                w_rdata[XLEN-1]            = (r_ms_fs == 2'b11);
            end
            CSR_MIE: begin
                w_rdata[3]  = r_mie[0];
                w_rdata[7]  = r_mie[1];
                w_rdata[11] = r_mie[2];
            end
            CSR_MIP: begin
                w_rdata[3]  = w_mip[0];
                w_rdata[7]  = w_mip[1];
                w_rdata[11] = w_mip[2];
            end
            CSR_MTVEC:    w_rdata = r_mtvec;
            CSR_MSCRATCH: w_rdata = r_mscratch;
            CSR_MEPC:     w_rdata = r_mepc;
            CSR_MCAUSE:   w_rdata = r_mcause;
            CSR_MTVAL:    w_rdata = r_mtval;
            CSR_MCYCLE:   w_rdata = w_mcycle;
            CSR_MINSTRET: w_rdata = w_minstret;
            CSR_MHARTID:  w_rdata = XLEN'(HART_ID);
            default: ;
        endcase
    end

    assign read_csr_data = (!rst && csr_rd_en && !w_illegal) ? w_rdata : '0;
    assign illegal_csr_o = ~rst & w_illegal;
    assign trap_valid_o  = ~rst & w_trap;
    assign trap_pc_o     = rst ? '0 : w_trap_pc;
    assign mret_pc_o     = rst ? '0 : r_mepc;

endmodule
`default_nettype wire
